// File: rtl/minterm_sweep_if.sv
// Handshake and result bundle for the minterm_sweep truth-table engine.
// The master side issues a sweep request with two minterm masks; the slave
// side streams the swept minterms and reports the comparison results.
interface minterm_sweep_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic         start;
    logic [W-1:0] mask_a;
    logic [W-1:0] mask_b;
    logic         busy;
    logic         valid;
    logic [N-1:0] idx;
    logic         val_a;
    logic         val_b;
    logic         done;
    logic         equal;
    logic [N:0]   ones;
    logic [N:0]   mism;
    logic [N-1:0] first_mism;

    modport master (
        output start, mask_a, mask_b,
        input  busy, valid, idx, val_a, val_b, done, equal, ones, mism, first_mism
    );

    modport slave (
        input  start, mask_a, mask_b,
        output busy, valid, idx, val_a, val_b, done, equal, ones, mism, first_mism
    );
endinterface

// File: rtl/minterm_sweep.sv
// Sequential truth-table sweeper: latches a function mask A and a reference
// mask B, walks every minterm once per clock, and reports the ones count of A,
// the mismatch count, the lowest mismatching minterm and an equivalence flag.
module minterm_sweep #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    minterm_sweep_if.slave   bus
);
    localparam int           W    = 1 << N;
    localparam logic [N-1:0] LAST = N'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] a_q, b_q;
    logic [N:0]   run_ones, run_mism;
    logic [N:0]   sum_ones, sum_mism;
    logic         found, found_nxt;
    logic [N-1:0] first_q, first_nxt;
    logic [N-1:0] idx_inc;
    logic         diff, last;

    // Fold the minterm currently on the outputs into the running totals, so
    // the final load at the end of the sweep includes the last minterm.
    always_comb begin
        diff      = bus.val_a ^ bus.val_b;
        last      = (bus.idx == LAST);
        idx_inc   = bus.idx + 1'b1;
        sum_ones  = run_ones + {{N{1'b0}}, bus.val_a};
        sum_mism  = run_mism + {{N{1'b0}}, diff};
        found_nxt = found | diff;
        first_nxt = found ? first_q : (diff ? bus.idx : '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the idx terminal count is an explicit exit, no wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SWEEP;
            S_SWEEP: if (last)      state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath: mask capture, minterm stream and result load.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q            <= '0;
            b_q            <= '0;
            run_ones       <= '0;
            run_mism       <= '0;
            found          <= 1'b0;
            first_q        <= '0;
            bus.busy       <= 1'b0;
            bus.valid      <= 1'b0;
            bus.idx        <= '0;
            bus.val_a      <= 1'b0;
            bus.val_b      <= 1'b0;
            bus.done       <= 1'b0;
            bus.equal      <= 1'b0;
            bus.ones       <= '0;
            bus.mism       <= '0;
            bus.first_mism <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Present minterm 0 straight from the inputs on the
                        // accepting edge; later minterms come from the copies.
                        a_q       <= bus.mask_a;
                        b_q       <= bus.mask_b;
                        run_ones  <= '0;
                        run_mism  <= '0;
                        found     <= 1'b0;
                        first_q   <= '0;
                        bus.busy  <= 1'b1;
                        bus.valid <= 1'b1;
                        bus.idx   <= '0;
                        bus.val_a <= bus.mask_a[0];
                        bus.val_b <= bus.mask_b[0];
                    end
                end
                S_SWEEP: begin
                    run_ones <= sum_ones;
                    run_mism <= sum_mism;
                    found    <= found_nxt;
                    first_q  <= first_nxt;
                    if (last) begin
                        bus.valid      <= 1'b0;
                        bus.idx        <= '0;
                        bus.val_a      <= 1'b0;
                        bus.val_b      <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.ones       <= sum_ones;
                        bus.mism       <= sum_mism;
                        bus.first_mism <= first_nxt;
                        bus.equal      <= (sum_mism == '0);
                    end else begin
                        bus.idx   <= idx_inc;
                        bus.val_a <= a_q[idx_inc];
                        bus.val_b <= b_q[idx_inc];
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                end
                default: begin
                    bus.busy  <= 1'b0;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_minterm_sweep.sv
// Self-checking bench for minterm_sweep: directed scenarios plus randomized
// masks, compared against a popcount / lowest-set-bit reference model.
module tb_minterm_sweep;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dones3 = 0;

    always #5 clk = ~clk;

    minterm_sweep_if #(.N(3)) bus3 ();
    minterm_sweep_if #(.N(1)) bus1 ();

    minterm_sweep #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
    minterm_sweep #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus3.done === 1'b1) dones3++;
    endtask

    function automatic int popcnt(input logic [7:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_diff(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        return 0;
    endfunction

    // Full N=3 run; with poke set, start is pulsed during SWEEP and DONE and
    // mask_a is scrambled after acceptance, none of which may alter results.
    task automatic run3(input logic [7:0] a, input logic [7:0] b, input bit poke);
        int d0 = dones3;
        int e_ones = popcnt(a, 8);
        int e_mism = popcnt(a ^ b, 8);
        int e_first = first_diff(a, b, 8);
        bus3.mask_a = a;
        bus3.mask_b = b;
        bus3.start  = 1'b1;
        tick();
        bus3.start = 1'b0;
        if (poke) bus3.mask_a = ~a;
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", bus3.valid, 1);
            chk("stream_busy", bus3.busy, 1);
            chk("stream_idx", bus3.idx, k);
            chk("stream_val_a", bus3.val_a, a[k]);
            chk("stream_val_b", bus3.val_b, b[k]);
            chk("done_early", bus3.done, 0);
            if (poke && k == 3) bus3.start = 1'b1;
            tick();
            bus3.start = 1'b0;
        end
        chk("done_pulse", bus3.done, 1);
        chk("done_busy", bus3.busy, 1);
        chk("done_valid", bus3.valid, 0);
        chk("ones", bus3.ones, e_ones);
        chk("mism", bus3.mism, e_mism);
        chk("first_mism", bus3.first_mism, e_first);
        chk("equal", bus3.equal, (e_mism == 0) ? 1 : 0);
        if (poke) bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        chk("idle_done", bus3.done, 0);
        chk("idle_busy", bus3.busy, 0);
        chk("idle_valid", bus3.valid, 0);
        chk("hold_ones", bus3.ones, e_ones);
        chk("hold_mism", bus3.mism, e_mism);
        chk("done_count", dones3 - d0, 1);
        if (poke) begin
            // A stray start during DONE must not have launched a new sweep.
            tick();
            chk("no_queued_start", bus3.busy, 0);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        int t1, t2, lim;
        bus3.start = 1'b0; bus3.mask_a = '0; bus3.mask_b = '0;
        bus1.start = 1'b0; bus1.mask_a = '0; bus1.mask_b = '0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", bus3.busy, 0);
        chk("rst_valid", bus3.valid, 0);
        chk("rst_idx", bus3.idx, 0);
        chk("rst_val_a", bus3.val_a, 0);
        chk("rst_val_b", bus3.val_b, 0);
        chk("rst_done", bus3.done, 0);
        chk("rst_equal", bus3.equal, 0);
        chk("rst_ones", bus3.ones, 0);
        chk("rst_mism", bus3.mism, 0);
        chk("rst_first", bus3.first_mism, 0);
        reset = 1'b0;
        tick();

        // Directed scenarios.
        run3(8'hC2, 8'hC2, 1'b0);
        run3(8'h36, 8'h66, 1'b0);
        run3(8'hC9, 8'hC9, 1'b0);
        run3(8'hFF, 8'h00, 1'b0);
        run3(8'h3C, 8'hA5, 1'b1);

        // Reset mid-sweep clears partial and prior results.
        bus3.mask_a = 8'h5A; bus3.mask_b = 8'h0F; bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        tick(); tick(); tick();
        chk("pre_reset_idx", bus3.idx, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", bus3.busy, 0);
        chk("mid_rst_valid", bus3.valid, 0);
        chk("mid_rst_idx", bus3.idx, 0);
        chk("mid_rst_ones", bus3.ones, 0);
        chk("mid_rst_mism", bus3.mism, 0);
        chk("mid_rst_first", bus3.first_mism, 0);
        chk("mid_rst_equal", bus3.equal, 0);
        run3(8'hFF, 8'hFF, 1'b0);

        // Start held high: done pulses W+2 cycles apart.
        bus3.mask_a = 8'h81; bus3.mask_b = 8'h18; bus3.start = 1'b1;
        lim = 0;
        tick();
        while (bus3.done !== 1'b1 && lim < 40) begin tick(); lim++; end
        chk("hold_done1", bus3.done, 1);
        chk("hold_ones1", bus3.ones, 2);
        t1 = cyc;
        tick();
        lim = 0;
        while (bus3.done !== 1'b1 && lim < 40) begin tick(); lim++; end
        chk("hold_done2", bus3.done, 1);
        t2 = cyc;
        chk("hold_spacing", t2 - t1, 10);
        chk("hold_first", bus3.first_mism, 0);
        bus3.start = 1'b0;
        tick();
        tick();

        // N=1 instance: latency of 2 edges.
        bus1.mask_a = 2'b10; bus1.mask_b = 2'b10; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("n1_idx0", bus1.idx, 0);
        chk("n1_val0", bus1.val_a, 0);
        chk("n1_done0", bus1.done, 0);
        tick();
        chk("n1_idx1", bus1.idx, 1);
        chk("n1_val1", bus1.val_a, 1);
        chk("n1_done1", bus1.done, 0);
        tick();
        chk("n1_done", bus1.done, 1);
        chk("n1_ones", bus1.ones, 1);
        chk("n1_mism", bus1.mism, 0);
        chk("n1_equal", bus1.equal, 1);
        tick();
        chk("n1_busy", bus1.busy, 0);

        // Randomized masks against the reference model.
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = (r % 4 == 0) ? ra : 8'($urandom);
            run3(ra, rb, (r % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
